// File: rtl/shift_engine_pkg.sv
// Shared encodings for the shift engine: shift modes and FSM states.
package shift_engine_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_LSL = 2'b01,
    MODE_ROR = 2'b10,
    MODE_ASR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_engine.sv
// Multi-mode shift register running a counted job of single-bit shifts.
// All state updates on the falling clock edge.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RST_VALUE = '0,
  parameter int unsigned          CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_DATA,
  input  logic             in_LOAD,
  input  logic             in_START,
  input  logic [CNT_W-1:0] in_COUNT,
  input  logic [1:0]       in_MODE,
  input  logic             in_SERIAL,
  output logic [WIDTH-1:0] out_DATA,
  output logic             out_SERIAL,
  output logic             out_BUSY,
  output logic             out_DONE
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LSR;
      data_q  <= RST_VALUE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_LOAD) begin
          data_d = in_DATA;
        end else if (in_START) begin
          mode_d  = mode_e'(in_MODE);
          cnt_d   = in_COUNT;
          state_d = (in_COUNT == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        case (mode_q)
          MODE_LSR: data_d = {in_SERIAL, data_q[WIDTH-1:1]};
          MODE_LSL: data_d = {data_q[WIDTH-2:0], in_SERIAL};
          MODE_ROR: data_d = {data_q[0], data_q[WIDTH-1:1]};
          MODE_ASR: data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          default:  data_d = data_q;
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        // Leave on the edge doing the last shift so BUSY lasts exactly N cycles.
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign out_DATA   = data_q;
  assign out_SERIAL = (mode_q == MODE_LSL) ? data_q[WIDTH-1] : data_q[0];
  assign out_BUSY   = (state_q == ST_SHIFT);
  assign out_DONE   = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Scoreboard bench for shift_engine: jobs push expected results, a monitor checks on DONE.
module tb_shift_engine;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  in_DATA = '0;
  logic          in_LOAD = 1'b0;
  logic          in_START = 1'b0;
  logic [CW-1:0] in_COUNT = '0;
  logic [1:0]    in_MODE = '0;
  logic          in_SERIAL = 1'b0;
  logic [W-1:0]  out_DATA;
  logic          out_SERIAL;
  logic          out_BUSY;
  logic          out_DONE;

  shift_engine #(.WIDTH(W), .RST_VALUE(8'h00), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_DATA   (in_DATA),
    .in_LOAD   (in_LOAD),
    .in_START  (in_START),
    .in_COUNT  (in_COUNT),
    .in_MODE   (in_MODE),
    .in_SERIAL (in_SERIAL),
    .out_DATA  (out_DATA),
    .out_SERIAL(out_SERIAL),
    .out_BUSY  (out_BUSY),
    .out_DONE  (out_DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned busy;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_err = 0;
  int unsigned n_chk = 0;
  logic [7:0]  model_reg = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: one shift expressed as integer arithmetic on the value.
  function automatic logic [7:0] model_step(input logic [7:0] r, input logic [1:0] m, input logic s);
    int v, sv;
    v  = int'(r);
    sv = s ? 1 : 0;
    case (m)
      2'd0:    v = (v / 2) + sv * 128;
      2'd1:    v = ((v * 2) % 256) + sv;
      2'd2:    v = (v / 2) + (v % 2) * 128;
      default: v = (v / 2) + (v >= 128 ? 128 : 0);
    endcase
    return v[7:0];
  endfunction

  // Monitor: samples on the rising edge, away from the falling active edge.
  int unsigned busy_seen = 0;
  always @(posedge clk) begin
    if (!rst) begin
      busy_seen = 0;
    end else begin
      if (out_BUSY) busy_seen++;
      if (out_DONE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(out_DONE), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_data", 32'(out_DATA), 32'(e.data));
          chk("busy_cycles", busy_seen, e.busy);
          chk("busy_in_done", 32'(out_BUSY), 32'd0);
        end
        busy_seen = 0;
      end
    end
  end

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      in_LOAD = 1'b0; in_START = 1'b0;
    end
  endtask

  task automatic do_load(input logic [7:0] v, input logic with_start);
    @(posedge clk);
    in_LOAD = 1'b1; in_DATA = v; in_START = with_start;
    in_MODE = 2'd2; in_COUNT = 4'd3;
    @(posedge clk);
    in_LOAD = 1'b0; in_START = 1'b0;
    model_reg = v;
    chk("load_data", 32'(out_DATA), 32'(v));
  endtask

  // Issue a job; garbage on control inputs during the job must be ignored.
  task automatic do_job(input logic [1:0] mode, input logic [3:0] cnt, input bit rand_ser,
                        input logic ser_val, input bit directed, input logic [7:0] exp_v,
                        input bit force_load);
    logic [7:0] r;
    logic       ser[16];
    logic       pre_ser;
    exp_t       e;
    r = model_reg;
    for (int unsigned k = 0; k < 16; k++) ser[k] = rand_ser ? 1'($urandom) : ser_val;
    for (int unsigned k = 0; k < cnt; k++) r = model_step(r, mode, ser[k]);
    pre_ser = (mode == 2'd1) ? model_reg[7] : model_reg[0];
    e.data = directed ? exp_v : r;
    e.busy = cnt;
    exp_q.push_back(e);
    model_reg = e.data;
    @(posedge clk);
    in_START = 1'b1; in_LOAD = 1'b0; in_MODE = mode; in_COUNT = cnt;
    for (int unsigned k = 0; k <= cnt; k++) begin
      @(posedge clk);
      if (k == 0) begin
        chk("busy_after_start", 32'(out_BUSY), (cnt != 0) ? 32'd1 : 32'd0);
        if (cnt != 0) chk("serial_pre_shift", 32'(out_SERIAL), 32'(pre_ser));
        else          chk("count0_data", 32'(out_DATA), 32'(e.data));
      end
      in_START  = 1'($urandom);
      in_LOAD   = force_load ? 1'b1 : 1'($urandom);
      in_DATA   = force_load ? 8'h12 : 8'($urandom);
      in_MODE   = 2'($urandom);
      in_COUNT  = 4'($urandom);
      in_SERIAL = (k < cnt) ? ser[k] : 1'($urandom);
    end
  endtask

  initial begin
    #2;
    chk("rst_data", 32'(out_DATA), 32'h00);
    chk("rst_busy", 32'(out_BUSY), 32'd0);
    chk("rst_done", 32'(out_DONE), 32'd0);
    chk("rst_serial", 32'(out_SERIAL), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    do_load(8'hB5, 1'b0);
    do_job(2'd0, 4'd3, 1'b0, 1'b0, 1'b1, 8'h16, 1'b0);
    do_load(8'hB5, 1'b0);
    do_job(2'd2, 4'd4, 1'b0, 1'b0, 1'b1, 8'h5B, 1'b0);
    do_load(8'hB5, 1'b0);
    do_job(2'd2, 4'd12, 1'b0, 1'b0, 1'b1, 8'h5B, 1'b0);
    do_load(8'h80, 1'b0);
    do_job(2'd3, 4'd2, 1'b0, 1'b0, 1'b1, 8'hE0, 1'b0);
    do_load(8'h81, 1'b0);
    do_job(2'd1, 4'd1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0);
    do_job(2'd0, 4'd0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0);
    do_load(8'h3C, 1'b0);
    do_job(2'd0, 4'd5, 1'b0, 1'b1, 1'b1, 8'hF9, 1'b1);
    do_load(8'h6D, 1'b1);
    idle(4);
    chk("pair_load_no_job", 32'(out_DATA), 32'h6D);
    chk("pair_no_busy", 32'(out_BUSY), 32'd0);

    // Back-to-back random jobs, occasionally reloading first.
    for (int unsigned j = 0; j < 40; j++) begin
      if ($urandom_range(0, 3) == 0) do_load(8'($urandom), 1'b0);
      do_job(2'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    end
    idle(3);

    // Asynchronous reset mid-job, between clock edges.
    do_load(8'hA7, 1'b0);
    @(posedge clk);
    in_START = 1'b1; in_MODE = 2'd2; in_COUNT = 4'd5;
    @(posedge clk);
    in_START = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_data", 32'(out_DATA), 32'h00);
    chk("midrst_busy", 32'(out_BUSY), 32'd0);
    chk("midrst_done", 32'(out_DONE), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    model_reg = 8'h00;
    idle(8);
    chk("post_rst_data", 32'(out_DATA), 32'h00);
    chk("post_rst_serial", 32'(out_SERIAL), 32'd0);
    do_job(2'd1, 4'd2, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    for (int unsigned t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    idle(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter WIDTH, default 8, data register width in bits; SHALL be >= 2.
REQ-002 Parameter RST_VALUE, default 0, register contents after reset.
REQ-003 Parameter CNT_W, default $clog2(WIDTH+1), width of the shift-count input.
REQ-004 clk  input  1  single clock; all state SHALL update on the falling edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_DATA  input  WIDTH  parallel load value.
REQ-007 in_LOAD  input  1  parallel load request.
REQ-008 in_START  input  1  start a shift job.
REQ-009 in_COUNT  input  CNT_W  number of single-bit shifts in the job.
REQ-010 in_MODE  input  2  shift mode: 00 logical right, 01 logical left, 10 rotate right, 11 arithmetic right.
REQ-011 in_SERIAL  input  1  fill bit for vacated positions in logical modes.
REQ-012 out_DATA  output  WIDTH  current register contents.
REQ-013 out_SERIAL  output  1  bit about to leave the register: LSB for modes 00, 10 and 11; MSB for mode 01.
REQ-014 out_BUSY  output  1  high while a job is in progress.
REQ-015 out_DONE  output  1  one-cycle pulse when a job completes.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-017 In IDLE with in_LOAD=1, the register SHALL take in_DATA at the next falling edge.
REQ-018 In IDLE with in_START=1 and in_LOAD=0, the block SHALL latch in_MODE and in_COUNT, then go to SHIFT, or to DONE if in_COUNT=0.
REQ-019 If in_LOAD and in_START are both high in IDLE, the load SHALL win and the start SHALL be ignored.
REQ-020 In SHIFT, each falling edge SHALL perform exactly one single-bit shift in the latched mode and decrement the remaining count.
REQ-021 SHIFT SHALL go to DONE on the edge that performs the last shift, so a job of N>0 shifts keeps out_BUSY high for exactly N cycles.
REQ-022 Mode 00 SHALL shift in_SERIAL into the MSB; mode 01 SHALL shift in_SERIAL into the LSB.
REQ-023 Mode 10 SHALL move the old LSB into the MSB; mode 11 SHALL replicate the old MSB.
REQ-024 in_SERIAL SHALL be sampled at each shift edge, not latched at start.
REQ-025 in_COUNT values greater than WIDTH SHALL be honoured literally, with no clamping (e.g., rotate by 12 on WIDTH=8 equals rotate by 4).
REQ-026 DONE SHALL last exactly one cycle, with out_DONE=1 and out_BUSY=0, then return to IDLE.
REQ-027 in_START and in_LOAD SHALL be ignored in DONE; the register SHALL hold.
REQ-028 in_LOAD and in_START SHALL be ignored while out_BUSY=1.
REQ-029 in_MODE and in_COUNT changes during a job SHALL have no effect.
REQ-030 out_DATA and out_SERIAL SHALL be driven directly from registered state, with no combinational path from inputs.
REQ-031 A new job SHALL be accepted in the IDLE cycle right after DONE; there is no extra dead cycle.

Reset
REQ-032 rst=0 SHALL immediately force: register = RST_VALUE, state = IDLE, count = 0, latched mode = 00.
REQ-033 Reset outputs SHALL be: out_BUSY=0, out_DONE=0, out_DATA=RST_VALUE, out_SERIAL per REQ-013 on RST_VALUE.
REQ-034 Reset asserted mid-job SHALL abort the job with no out_DONE pulse.
REQ-035 After reset release, the first falling edge SHALL be treated as an IDLE cycle.

Structure
REQ-036 Package shift_engine_pkg SHALL hold the mode encodings (MODE_LSR, MODE_LSL, MODE_ROR, MODE_ASR) and the FSM state enum.
REQ-037 The block SHALL be a single module with no sub-module; the counter and datapath are inline.

Verification (WIDTH=8, RST_VALUE=0)
REQ-038 Load 0xB5, then start mode 00, count 3, in_SERIAL=0 -> out_BUSY high 3 cycles, out_DATA=0x16, then one out_DONE pulse.
REQ-039 Load 0xB5, then start mode 10, count 4 -> out_DATA=0x5B; with count 12 -> also 0x5B after 12 busy cycles.
REQ-040 Load 0x80, mode 11, count 2 -> 0xE0; load 0x81, mode 01, count 1, in_SERIAL=1 -> 0x03, with out_SERIAL=1 before the shift.
REQ-041 Start with count 0 -> out_DONE pulse on the next edge, out_BUSY never high, out_DATA unchanged.
REQ-042 Load 0x12 asserted during a 5-shift job, plus in_LOAD and in_START together in IDLE -> the mid-job load is ignored; the simultaneous pair loads only, and no job starts.
REQ-043 rst=0 pulsed asynchronously mid-job, between edges -> out_DATA=0x00 and out_BUSY=0 immediately, with no out_DONE pulse afterwards.
